// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - debounced ten-key front-panel encoder with valid/ready digit output
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_in,
  output logic [3:0] binary_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       error_out
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

  localparam logic [7:0] DB_CNT = 8'(DEBOUNCE_CYCLES);

  state_t     state_q, state_d;
  logic [9:0] sync1_q, sync1_d;
  logic [9:0] sync2_q, sync2_d;
  logic [9:0] cap_q, cap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] binary_q, binary_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  logic [9:0] key_sync;
  logic [7:0] cnt_inc;
  logic [3:0] cap_idx;
  logic       cap_one_hot;

  assign key_sync    = sync2_q;
  assign cnt_inc     = cnt_q + 8'd1;
  assign cap_one_hot = (cap_q != 10'd0) && ((cap_q & (cap_q - 10'd1)) == 10'd0);

  always_comb begin
    cap_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (cap_q[i]) cap_idx = 4'(i);
    end
  end

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    valid_d  = valid_q;
    error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_sync != 10'd0) begin
          cap_d   = key_sync;
          cnt_d   = 8'd1;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change, including a bounce to all-zero, abandons this capture.
        if (key_sync != cap_q) begin
          state_d = IDLE;
        end else if (cnt_q < DB_CNT) begin
          cnt_d = cnt_inc;
        end else if (cap_one_hot) begin
          binary_d = cap_idx;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          error_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = RELEASE;
        end
      end
      HOLD: begin
        if (valid_q && ready_in) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (key_sync != 10'd0) begin
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_CNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 10'd0;
      sync2_q  <= 10'd0;
      cap_q    <= 10'd0;
      cnt_q    <= 8'd0;
      binary_q <= 4'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign binary_out = binary_q;
  assign valid_out  = valid_q;
  assign error_out  = error_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - vector table plus scoreboard bench for keypad_encoder
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_in;
  logic [3:0] binary_out;
  logic       valid_out;
  logic       ready_in;
  logic       error_out;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [9:0] keys;
    logic       is_err;
    logic [3:0] digit;
  } vec_t;

  typedef struct packed {
    logic       is_err;
    logic [3:0] digit;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];

  keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .binary_out (binary_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .error_out  (error_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Every transfer or error pulse seen on the outputs consumes one scoreboard entry.
  task automatic sb_check(input logic is_err, input logic [3:0] digit);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected %s digit=%0d at %0t", is_err ? "error" : "digit", digit, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err || (!is_err && e.digit != digit)) begin
        n_fail++;
        $display("FAIL scoreboard: got err=%0b digit=%0d, expected err=%0b digit=%0d at %0t",
                 is_err, digit, e.is_err, e.digit, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out && ready_in) sb_check(1'b0, binary_out);
      if (error_out) sb_check(1'b1, 4'd0);
    end
  end

  // Key pattern applied before edge 1; with ready high the result appears after edge 7 only.
  task automatic press_timed(input logic [9:0] keys, input logic is_err, input logic [3:0] digit,
                             input int hold);
    exp_q.push_back('{is_err, digit});
    key_in = keys;
    for (int e = 1; e <= hold; e++) begin
      tick();
      if (is_err) begin
        chk("err_pulse", 32'(error_out), 32'(e == 7));
        chk("err_no_valid", 32'(valid_out), 32'd0);
      end else begin
        chk("valid_timing", 32'(valid_out), 32'(e == 7));
        chk("err_quiet", 32'(error_out), 32'd0);
      end
    end
  endtask

  task automatic release_keys(input int n);
    key_in = 10'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{10'(1 << i), 1'b0, 4'(i)};
    vecs[10] = '{10'h006, 1'b1, 4'd0};
    vecs[11] = '{10'h300, 1'b1, 4'd0};

    rst_n    = 1'b0;
    key_in   = 10'd0;
    ready_in = 1'b1;
    #1;
    chk("reset_binary", 32'(binary_out), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_error", 32'(error_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 12; v++) begin
      press_timed(vecs[v].keys, vecs[v].is_err, vecs[v].digit, 10);
      release_keys(8);
    end
    chk("binary_kept", 32'(binary_out), 32'd9);

    // Key 3 bounces 1,0,1 then holds; timing counts from the final stable application.
    key_in = 10'h008;
    tick();
    key_in = 10'h000;
    tick();
    press_timed(10'h008, 1'b0, 4'd3, 10);
    release_keys(8);

    // Back-pressure on key 0 while the keys change to key 5.
    ready_in = 1'b0;
    exp_q.push_back('{1'b0, 4'd0});
    key_in = 10'h001;
    for (int i = 0; i < 7; i++) tick();
    chk("bp_valid_up", 32'(valid_out), 32'd1);
    key_in = 10'h020;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_held", 32'(valid_out), 32'd1);
      chk("bp_binary_held", 32'(binary_out), 32'd0);
    end
    ready_in = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(valid_out), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    release_keys(8);

    // Long hold of key 4, then a one-cycle re-press inside the release window.
    press_timed(10'h010, 1'b0, 4'd4, 100);
    key_in = 10'h000;
    tick();
    tick();
    key_in = 10'h010;
    tick();
    release_keys(8);
    press_timed(10'h010, 1'b0, 4'd4, 10);
    release_keys(8);

    // Asynchronous reset while holding digit 2 un-acknowledged.
    ready_in = 1'b0;
    key_in = 10'h004;
    for (int i = 0; i < 8; i++) tick();
    chk("hold_valid", 32'(valid_out), 32'd1);
    chk("hold_binary", 32'(binary_out), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(valid_out), 32'd0);
    chk("async_binary", 32'(binary_out), 32'd0);
    chk("async_error", 32'(error_out), 32'd0);
    tick();
    tick();
    rst_n = 1'b0;
    ready_in = 1'b1;
    #1;
    rst_n = 1'b1;
    press_timed(10'h004, 1'b0, 4'd2, 10);
    release_keys(8);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Front-panel input encoder for the microwave controller: samples ten raw digit keys (0-9), synchronises and debounces them, and encodes one accepted key press into a 4-bit binary digit delivered over a valid/ready handshake. It is the input-side counterpart of the 7-segment display decoder: keys become binary digits here, and digits become segment patterns at the display. It sits between the front-panel key pins and the time-entry logic. A multi-key press is rejected and flagged, not encoded.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples needed to accept a press or a release; legal range 1..255.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_in  input  10  raw key levels, active-high, asynchronous to clk; bit i means digit i.
- binary_out  output  4  encoded digit 0..9; held stable while valid_out=1.
- valid_out  output  1  binary_out holds an accepted digit.
- ready_in  input  1  consumer accepts the digit when valid_out=1 and ready_in=1 on the same edge.
- error_out  output  1  one-cycle pulse: a debounced press had more than one key set.

## Operation
- Synchroniser: two-flop chain per key bit, key_sync = second stage. All decisions use key_sync only.
- Internal registers: captured vector cap[9:0]; counter cnt, 8 bits.
- FSM states: IDLE, DEBOUNCE, HOLD, RELEASE.
- IDLE, key_sync != 0: cap <= key_sync, cnt <= 1, go to DEBOUNCE.
- DEBOUNCE, key_sync == cap, cnt < DEBOUNCE_CYCLES: cnt++.
- DEBOUNCE, key_sync == cap, cnt == DEBOUNCE_CYCLES, cap one-hot: binary_out <= index of the set bit, valid_out <= 1, go to HOLD.
- DEBOUNCE, same condition, cap not one-hot: error_out <= 1 for exactly one cycle, go to RELEASE with cnt <= 0.
- DEBOUNCE, key_sync != cap (including all-zero): go to IDLE. No output. The new vector is recaptured on the next IDLE cycle.
- HOLD: valid_out and binary_out are held regardless of key_sync. When valid_out & ready_in: valid_out <= 0, go to RELEASE with cnt <= 0.
- RELEASE, key_sync == 0: cnt++. When the increment would reach DEBOUNCE_CYCLES, go to IDLE.
- RELEASE, key_sync != 0: cnt <= 0.
- Held keys never auto-repeat. Exactly one digit or one error is produced per press-release cycle.
- binary_out keeps its last value after valid_out drops. It changes only when a new digit is accepted.

## Timing
- Reset values: binary_out=0, valid_out=0, error_out=0, state IDLE, sync flops 0, cap=0, cnt=0.
- Reset is asynchronous: asserting rst_n forces all reset values immediately, even mid-debounce or in HOLD.
- A key held across reset release is synchronised and debounced as a new press.
- Press latency: key_in stable from before edge k makes valid_out rise after edge k+2+DEBOUNCE_CYCLES. With the default, valid_out rises after edge k+6.
- Error pulse follows the same timing: error_out is high for the single cycle after edge k+2+DEBOUNCE_CYCLES.
- Handshake: transfer occurs on an edge with valid_out=1 and ready_in=1. valid_out is low after that edge.
- ready_in may be held high permanently; a digit is then valid for exactly one cycle.
- ready_in while valid_out=0 has no effect.
- Release: RELEASE needs DEBOUNCE_CYCLES consecutive zero samples. Any bounce restarts the count.
- Next press: IDLE can capture on the cycle after RELEASE exits.
- Simultaneous events:
  - A key change in the same cycle as the handshake is ignored; RELEASE handles it.
  - A second key added during HOLD has no effect on binary_out.

## Test plan
- Clean press of key 7 (key_in=10'h080), default parameter, ready_in=1: binary_out=7, valid_out high for exactly 1 cycle, rising 6 edges after the first sampling edge. error_out stays 0.
- Bounce: key 3 toggles 1,0,1 at 1-cycle intervals, then held 10 cycles: exactly one valid_out with binary_out=3, timed from the final stable edge.
- Back-pressure: press key 0, ready_in=0 for 20 cycles while key_in also changes to key 5: valid_out stays 1 and binary_out stays 0 throughout. Raise ready_in: valid_out falls after that edge.
- Multi-key: key_in=10'h006 held: one 1-cycle error_out pulse, valid_out stays 0. Release, then press key 9: binary_out=9, valid_out=1.
- No repeat / release bounce: hold key 4 for 100 cycles, then release with a 1-cycle re-press inside the release window: exactly one digit 4 is produced. A press after a clean 4-cycle zero window produces a new digit.
- Async reset in HOLD: drop rst_n mid-cycle. valid_out, binary_out and error_out go to 0 immediately. With key 2 still held after reset release, digit 2 is produced after 2+DEBOUNCE_CYCLES edges.
